bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
Parametrised BCD time-of-count core for the stopwatch family; generalises the fixed MM:SS counter to N two-digit fields (SS, MM, optional HH), each with a configurable modulus.
Adds count-down mode with sticky expiry, lap capture and preset load, alongside the existing per-field adjust.
Sits between the clock divider (which supplies the 1 Hz and 2 Hz single-cycle strobes) and the seven-segment display multiplexer (which consumes time_bcd).

Parameters:
N_FIELDS, 2, number of two-digit fields; field 0 = seconds, 1 = minutes, 2 = hours; legal range 1..3
TOP_MAX, 59, maximum value of the top field (field N_FIELDS-1), e.g. 23 for hours; lower fields are always 59; legal 1..99

Ports:
clk  in  1  system clock
RESET  in  1  synchronous active-high reset
tick_cnt  in  1  1 Hz count strobe, one clk wide
tick_adj  in  1  2 Hz adjust strobe, one clk wide
pause  in  1  1 = freeze counting (adjust, load and lap still act)
adj  in  1  1 = adjust mode; tick_cnt is ignored
sel  in  2  field index to adjust
dir  in  1  0 = count up, 1 = count down
lap  in  1  one-cycle pulse: capture the current time
load  in  1  one-cycle pulse: preset time from load_bcd
load_bcd  in  8*N_FIELDS  preset value, field 0 in the LSBs, tens digit above units digit
time_bcd  out  8*N_FIELDS  current time, same packing as load_bcd
lap_bcd  out  8*N_FIELDS  last captured time
lap_valid  out  1  high once a lap has been captured
wrap  out  1  one-cycle pulse: top field rolled over (up) or reached all-zero (down)
expired  out  1  sticky: down-count reached 00..00

Behaviour:
- Reset: all outputs are 0 on the clk edge where RESET=1, and RESET overrides every other input. This differs from the MM:SS counter, where pause masked reset.
- All outputs are registered. An update driven by a strobe is visible on the clk edge after the strobe cycle.
- Priority per cycle: RESET > load > adjust (adj & tick_adj) > count (!adj & !pause & tick_cnt).
- lap is evaluated in parallel with that priority chain, not inside it.
- Digit rule: units digit runs 0..9. Tens digit runs 0..5 for fields below the top, and 0..TOP_MAX/10 for the top field.
  - Field modulus is 60 below the top field and TOP_MAX+1 for the top field.
- Count up: field 0 increments. A field at its max goes to 00 and carries into the next field.
  - When the top field goes from TOP_MAX to 00 (all fields become 0), assert wrap for 1 cycle.
- Count down: field 0 decrements. A field at 00 goes to its max and borrows from the next field.
  - A tick that brings the time to all-zero asserts wrap for 1 cycle and sets expired.
  - While expired=1 with dir=1, further tick_cnt strobes hold all-zero and produce no further wrap.
  - A tick with dir=1 while the time is already all-zero (and expired=0) sets expired, with no change and no wrap.
- expired clears on RESET, on load, or on any cycle with dir=0.
- Adjust: on tick_adj with adj=1, field sel increments modulo its own max. There is no carry into neighbouring fields, and dir is ignored.
  - sel >= N_FIELDS: no change.
- Load: time_bcd <= load_bcd on the next edge, and expired clears.
  - A field that is non-BCD or above its max loads as its max.
- Lap: when lap=1, lap_bcd <= the time_bcd value present in that cycle (the pre-update value), and lap_valid <= 1.
  - lap_valid stays high until RESET.
  - lap coincident with load or a count tick captures the old value.
- adj=1 with tick_cnt=1: no count. pause has no effect on adjust, load or lap.
- No internal clock dividers: strobes come from the clock divider.

Decomposition:
- Package bcd_time_pkg holds:
  - the bcd_digit_t (4-bit) and bcd_field_t (2×digit) typedefs
  - constants SEC_MIN_MAX=59 and HOUR_MAX_24=23
  - the helper function bcd_clamp(field, max)
- One sub-module, bcd_field: a two-digit modulo counter.
  - Inputs: inc, dec, load, load_val, MAX parameter.
  - Outputs: value, carry_out (inc at max), borrow_out (dec at 00).
  - The top level instantiates N_FIELDS copies with a generate loop, chaining carry and borrow into the next field's inc/dec. Adjust drives inc with carry suppressed.

Test Plan:
- N_FIELDS=2, count up from 59:58, two tick_cnt strobes -> 59:59, then 00:00, with wrap high for exactly 1 cycle on the second update.
- N_FIELDS=3, TOP_MAX=23, load 23:59:59, one tick -> 00:00:00 and wrap. Load 09:59:59, one tick -> 10:00:00.
- dir=1, load 00:00:02, three ticks -> 00:00:01, 00:00:00 (wrap and expired set), 00:00:00 (no wrap, expired stays). Then dir=0 for one cycle -> expired=0.
- adj=1, sel=1, time 00:59, one tick_adj -> 01:59? no: minutes field 00 -> 01, seconds untouched, result 01:59. Then sel=0 from 01:59 -> 01:00 with no carry. sel=3 -> unchanged.
- pause=1, 5 tick_cnt strobes -> time unchanged. lap during pause -> lap_bcd equals the frozen time and lap_valid=1. RESET asserted with pause=1 -> all outputs 0 on the next edge.
- lap and tick_cnt in the same cycle at 00:09 -> lap_bcd=00:09, time_bcd=00:10. load of 00:7A -> time_bcd=00:59.

Source files
------------

// File: rtl/bcd_time_pkg.sv
// Shared BCD types, field limits and preset clamping for the stopwatch time counter.
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_field_t;

  localparam int SEC_MIN_MAX = 59;
  localparam int HOUR_MAX_24 = 23;

  function automatic bcd_field_t to_bcd(input int v);
    bcd_field_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

  // Non-BCD or over-range presets saturate to the field maximum.
  function automatic bcd_field_t bcd_clamp(input bcd_field_t f, input int max_val);
    int v;
    if (f.tens > 4'd9 || f.units > 4'd9) return to_bcd(max_val);
    v = 10 * int'(f.tens) + int'(f.units);
    if (v > max_val) return to_bcd(max_val);
    return f;
  endfunction

endpackage

// File: rtl/bcd_field.sv
// Two-digit BCD modulo-(MAX+1) counter with preset; carry/borrow flag a wrap on this cycle's step.
module bcd_field
  import bcd_time_pkg::*;
#(
  parameter int MAX = SEC_MIN_MAX
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  bcd_field_t load_val,
  output bcd_field_t value,
  output logic       carry_out,
  output logic       borrow_out
);

  localparam bcd_field_t MAX_BCD = to_bcd(MAX);

  logic at_max;
  logic at_zero;

  assign at_max     = (value == MAX_BCD);
  assign at_zero    = (value == '0);
  assign carry_out  = inc & at_max;
  assign borrow_out = dec & at_zero;

  always_ff @(posedge clk) begin
    if (RESET) begin
      value <= '0;
    end else if (load) begin
      value <= bcd_clamp(load_val, MAX);
    end else if (inc) begin
      if (at_max)                   value <= '0;
      else if (value.units == 4'd9) value <= {value.tens + 4'd1, 4'd0};
      else                          value <= {value.tens, value.units + 4'd1};
    end else if (dec) begin
      if (at_zero)                  value <= MAX_BCD;
      else if (value.units == 4'd0) value <= {value.tens - 4'd1, 4'd9};
      else                          value <= {value.tens, value.units - 4'd1};
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// N-field BCD time counter: up/down count with sticky expiry, per-field adjust, preset load and lap capture.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int N_FIELDS = 2,
  parameter int TOP_MAX  = 59
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  tick_cnt,
  input  logic                  tick_adj,
  input  logic                  pause,
  input  logic                  adj,
  input  logic [1:0]            sel,
  input  logic                  dir,
  input  logic                  lap,
  input  logic                  load,
  input  logic [8*N_FIELDS-1:0] load_bcd,
  output logic [8*N_FIELDS-1:0] time_bcd,
  output logic [8*N_FIELDS-1:0] lap_bcd,
  output logic                  lap_valid,
  output logic                  wrap,
  output logic                  expired
);

  localparam int W = 8 * N_FIELDS;

  logic adj_op;
  logic cnt_op;
  logic cnt_up;
  logic cnt_dn;
  logic all_zero;
  logic at_one;
  logic unused_borrow;

  logic [N_FIELDS-1:0] inc;
  logic [N_FIELDS-1:0] dec;
  logic [N_FIELDS-1:0] carry;
  logic [N_FIELDS-1:0] borrow;

  assign adj_op   = !load & adj & tick_adj;
  assign cnt_op   = !load & !adj & !pause & tick_cnt;
  assign all_zero = (time_bcd == '0);
  assign at_one   = (time_bcd == W'(1));
  assign cnt_up   = cnt_op & !dir;
  // Down-count stalls once expired, and at all-zero (that tick only sets expired).
  assign cnt_dn   = cnt_op & dir & !expired & !all_zero;

  assign unused_borrow = borrow[N_FIELDS-1];

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
    localparam int FMAX = (i == N_FIELDS - 1) ? TOP_MAX : SEC_MIN_MAX;
    bcd_field_t value;

    if (i == 0) begin : g_lsb
      assign inc[i] = cnt_up | (adj_op & (sel == 2'(i)));
      assign dec[i] = cnt_dn;
    end else begin : g_upper
      // Carry only ripples on a count step; an adjust wrap stays within its field.
      assign inc[i] = (cnt_op & carry[i-1]) | (adj_op & (sel == 2'(i)));
      assign dec[i] = borrow[i-1];
    end

    bcd_field #(.MAX(FMAX)) u_field (
      .clk       (clk),
      .RESET     (RESET),
      .inc       (inc[i]),
      .dec       (dec[i]),
      .load      (load),
      .load_val  (load_bcd[8*i +: 8]),
      .value     (value),
      .carry_out (carry[i]),
      .borrow_out(borrow[i])
    );

    assign time_bcd[8*i +: 8] = value;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      wrap      <= 1'b0;
      expired   <= 1'b0;
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else begin
      wrap <= (cnt_up & carry[N_FIELDS-1]) | (cnt_dn & at_one);
      if (load || !dir)                   expired <= 1'b0;
      else if (cnt_op && (all_zero || at_one)) expired <= 1'b1;
      if (lap) begin
        lap_bcd   <= time_bcd;
        lap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: MM:SS and HH:MM:SS (24 h) instances, directed vector table then random traffic.
module tb_bcd_time_counter;

  logic        clk;
  logic        RESET;
  logic        tick_cnt;
  logic        tick_adj;
  logic        pause;
  logic        adj;
  logic [1:0]  sel;
  logic        dir;
  logic        lap;
  logic        load;
  logic [15:0] load_bcd2;
  logic [23:0] load_bcd3;

  logic [15:0] time2, lap2;
  logic [23:0] time3, lap3;
  logic        lv2, lv3, w2, w3, e2, e3;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_time_counter #(.N_FIELDS(2), .TOP_MAX(59)) dut2 (
    .clk(clk), .RESET(RESET), .tick_cnt(tick_cnt), .tick_adj(tick_adj), .pause(pause),
    .adj(adj), .sel(sel), .dir(dir), .lap(lap), .load(load), .load_bcd(load_bcd2),
    .time_bcd(time2), .lap_bcd(lap2), .lap_valid(lv2), .wrap(w2), .expired(e2)
  );

  bcd_time_counter #(.N_FIELDS(3), .TOP_MAX(23)) dut3 (
    .clk(clk), .RESET(RESET), .tick_cnt(tick_cnt), .tick_adj(tick_adj), .pause(pause),
    .adj(adj), .sel(sel), .dir(dir), .lap(lap), .load(load), .load_bcd(load_bcd3),
    .time_bcd(time3), .lap_bcd(lap3), .lap_valid(lv3), .wrap(w3), .expired(e3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: time held as a plain count of base-unit ticks per instance
  int nfk[2] = '{2, 3};
  int tmk[2] = '{59, 23};
  int mt[2], ml[2];
  bit me[2], mw[2], mlv[2];

  function automatic int pw(input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 60;
    return p;
  endfunction

  function automatic int fmax(input int nf, input int tm, input int i);
    return (i == nf - 1) ? tm : 59;
  endfunction

  function automatic int fld(input int t, input int nf, input int i);
    int v = t / pw(i);
    return (i == nf - 1) ? v : v % 60;
  endfunction

  function automatic logic [23:0] to_vec(input int t, input int nf);
    logic [23:0] r = '0;
    int v;
    for (int i = 0; i < nf; i++) begin
      v = fld(t, nf, i);
      r[8*i +: 8] = 8'(((v / 10) << 4) | (v % 10));
    end
    return r;
  endfunction

  function automatic int clamp_f(input logic [7:0] b, input int mx);
    int v;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return mx;
    v = 10 * int'(b[7:4]) + int'(b[3:0]);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int from_vec(input logic [23:0] b, input int nf, input int tm);
    int t = 0;
    for (int i = 0; i < nf; i++) t = t + clamp_f(b[8*i +: 8], fmax(nf, tm, i)) * pw(i);
    return t;
  endfunction

  task automatic model_step(input int k);
    int nf, tm, m, old, s;
    int f[3];
    logic [23:0] ldv;
    nf  = nfk[k];
    tm  = tmk[k];
    m   = pw(nf - 1) * (tm + 1);
    old = mt[k];
    ldv = (k == 0) ? {8'h00, load_bcd2} : load_bcd3;
    mw[k] = 1'b0;
    if (lap) begin
      ml[k]  = old;
      mlv[k] = 1'b1;
    end
    if (RESET) begin
      mt[k] = 0; me[k] = 1'b0; ml[k] = 0; mlv[k] = 1'b0;
    end else if (load) begin
      mt[k] = from_vec(ldv, nf, tm);
      me[k] = 1'b0;
    end else if (adj && tick_adj) begin
      s = int'(sel);
      if (s < nf) begin
        for (int i = 0; i < 3; i++) f[i] = (i < nf) ? fld(old, nf, i) : 0;
        f[s] = (f[s] + 1) % (fmax(nf, tm, s) + 1);
        mt[k] = 0;
        for (int i = 0; i < nf; i++) mt[k] = mt[k] + f[i] * pw(i);
      end
      if (!dir) me[k] = 1'b0;
    end else if (!adj && !pause && tick_cnt) begin
      if (!dir) begin
        mt[k] = (old + 1) % m;
        mw[k] = (mt[k] == 0);
        me[k] = 1'b0;
      end else if (!me[k]) begin
        if (old == 0) begin
          me[k] = 1'b1;
        end else begin
          mt[k] = old - 1;
          if (mt[k] == 0) begin
            mw[k] = 1'b1;
            me[k] = 1'b1;
          end
        end
      end
    end else if (!dir) begin
      me[k] = 1'b0;
    end
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_check();
    chk("m2_time",    {8'h00, time2}, to_vec(mt[0], 2));
    chk("m2_lap",     {8'h00, lap2},  to_vec(ml[0], 2));
    chk("m2_lapv",    {23'd0, lv2},   {23'd0, mlv[0]});
    chk("m2_wrap",    {23'd0, w2},    {23'd0, mw[0]});
    chk("m2_expired", {23'd0, e2},    {23'd0, me[0]});
    chk("m3_time",    time3,          to_vec(mt[1], 3));
    chk("m3_lap",     lap3,           to_vec(ml[1], 3));
    chk("m3_lapv",    {23'd0, lv3},   {23'd0, mlv[1]});
    chk("m3_wrap",    {23'd0, w3},    {23'd0, mw[1]});
    chk("m3_expired", {23'd0, e3},    {23'd0, me[1]});
  endtask

  // driver: one clock cycle with the given inputs
  task automatic drive(input logic r, input logic tc, input logic ta, input logic pa,
                       input logic ad, input logic [1:0] sl, input logic dr, input logic lp,
                       input logic ld, input logic [15:0] l2, input logic [23:0] l3);
    RESET = r; tick_cnt = tc; tick_adj = ta; pause = pa; adj = ad; sel = sl;
    dir = dr; lap = lp; load = ld; load_bcd2 = l2; load_bcd3 = l3;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    model_check();
  endtask

  typedef struct {
    logic        rst, tc, ta, pa, ad;
    logic [1:0]  sl;
    logic        dr, lp, ld;
    logic [15:0] l2;
    logic [23:0] l3;
    logic [15:0] t2;
    logic [23:0] t3;
    logic [1:0]  w;     // {wrap of HH:MM:SS, wrap of MM:SS}
    logic        e;
    logic        cl;    // compare lap outputs on this row
    logic [15:0] lp2;
    logic [23:0] lp3;
    logic        lv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int rst, input int tc, input int ta, input int pa, input int ad,
                              input int sl, input int dr, input int lp, input int ld,
                              input logic [15:0] l2, input logic [23:0] l3,
                              input logic [15:0] t2, input logic [23:0] t3, input int w, input int e,
                              input int cl, input logic [15:0] lp2, input logic [23:0] lp3, input int lv);
    vec_t v;
    v.rst = rst[0]; v.tc = tc[0]; v.ta = ta[0]; v.pa = pa[0]; v.ad = ad[0]; v.sl = 2'(sl);
    v.dr = dr[0]; v.lp = lp[0]; v.ld = ld[0]; v.l2 = l2; v.l3 = l3; v.t2 = t2; v.t3 = t3;
    v.w = 2'(w); v.e = e[0]; v.cl = cl[0]; v.lp2 = lp2; v.lp3 = lp3; v.lv = lv[0];
    return v;
  endfunction

  initial begin
    logic        r_rst, r_tc, r_ta, r_pa, r_ad, r_dr, r_lp, r_ld;
    logic [1:0]  r_sl;
    logic [15:0] r_l2;
    logic [23:0] r_l3;

    RESET = 1'b1; tick_cnt = 1'b0; tick_adj = 1'b0; pause = 1'b0; adj = 1'b0; sel = 2'd0;
    dir = 1'b0; lap = 1'b0; load = 1'b0; load_bcd2 = '0; load_bcd3 = '0;

    //             rst tc ta pa ad sl dr lp ld  load2     load3        time2     time3      w e  cl lap2   lap3        lv
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 0, 0, 1, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5958, 24'h235959, 16'h5958, 24'h235959, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h5959, 24'h000000, 2, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000001, 1, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000001, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0959, 24'h095959, 16'h0959, 24'h095959, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h1000, 24'h100000, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0002, 24'h000002, 16'h0002, 24'h000002, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 24'h000000, 16'h0001, 24'h000001, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 3, 1, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 0, 1, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 0, 1, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 0, 1, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0059, 24'h000059, 16'h0059, 24'h000059, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 16'h0000, 24'h000000, 16'h0159, 24'h000159, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0100, 24'h000100, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 1, 0, 1, 3, 0, 0, 0, 16'h0000, 24'h000000, 16'h0100, 24'h000100, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 0, 16'h0000, 24'h000000, 16'h0100, 24'h010100, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0100, 24'h010100, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 0, 16'h0000, 24'h000000, 16'h0200, 24'h010200, 0, 0, 0, 16'h0, 24'h0,      0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0200, 24'h010200, 0, 0, 0, 16'h0, 24'h0,    0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0000, 24'h000000, 16'h0200, 24'h010200, 0, 0, 1, 16'h0200, 24'h010200, 1));
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 1, 16'h5958, 24'h235959, 16'h0000, 24'h000000, 0, 0, 1, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0009, 24'h000009, 16'h0009, 24'h000009, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 24'h000000, 16'h0010, 24'h000010, 0, 0, 1, 16'h0009, 24'h000009, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h007A, 24'h997A05, 16'h0059, 24'h235905, 0, 0, 1, 16'h0010, 24'h000010, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h6A61, 24'h24609F, 16'h5959, 24'h235959, 0, 0, 0, 16'h0, 24'h0,      0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 24'h000000, 16'h0000, 24'h000000, 3, 0, 0, 16'h0, 24'h0,      0));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].tc, vq[i].ta, vq[i].pa, vq[i].ad, vq[i].sl, vq[i].dr, vq[i].lp,
            vq[i].ld, vq[i].l2, vq[i].l3);
      chk($sformatf("v%0d_time2", i),   {8'h00, time2}, {8'h00, vq[i].t2});
      chk($sformatf("v%0d_time3", i),   time3,          vq[i].t3);
      chk($sformatf("v%0d_wrap", i),    {22'd0, w3, w2}, {22'd0, vq[i].w});
      chk($sformatf("v%0d_expired", i), {22'd0, e3, e2}, {22'd0, vq[i].e, vq[i].e});
      if (vq[i].cl) begin
        chk($sformatf("v%0d_lap2", i),  {8'h00, lap2}, {8'h00, vq[i].lp2});
        chk($sformatf("v%0d_lap3", i),  lap3,          vq[i].lp3);
        chk($sformatf("v%0d_lapv", i),  {22'd0, lv3, lv2}, {22'd0, vq[i].lv, vq[i].lv});
      end
    end

    // random traffic against the model
    r_dr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_ld  = ($urandom_range(0, 19) == 0);
      r_lp  = ($urandom_range(0, 5) == 0);
      r_tc  = ($urandom_range(0, 1) == 1);
      r_ta  = ($urandom_range(0, 3) == 0);
      r_ad  = ($urandom_range(0, 4) == 0);
      r_pa  = ($urandom_range(0, 7) == 0);
      r_sl  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) r_dr = ~r_dr;
      case ($urandom_range(0, 3))
        0: r_l3 = 24'($urandom());
        1: r_l3 = 24'($urandom_range(0, 5));
        2: r_l3 = 24'h235958;
        default: r_l3 = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      endcase
      r_l2 = (r_l3 == 24'h235958) ? 16'h5958 : r_l3[15:0];
      drive(r_rst, r_tc, r_ta, r_pa, r_ad, r_sl, r_dr, r_lp, r_ld, r_l2, r_l3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
